aximm_error_slave: RTL and testbench

AXI4 memory-mapped slave terminator; the responder-side counterpart of the master tie-off.
- Sits on unused or unmapped slave ports of the platform interconnect.
- Accepts every write and read transaction, completes it with protocol-correct handshakes and burst lengths, and returns a fixed error response, so initiators never hang.
- Read and write channels are handled by independent state machines.

---
 rtl/aximm_error_slave.sv | 157 +++++++++++++++
 tb/tb_aximm_error_slave.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aximm_error_slave.sv
// AXI4 slave terminator: accepts every transaction on an unmapped port and
// completes it with a fixed error response so initiators never hang.
module aximm_error_slave #(
   parameter int unsigned C_AXIMM_ADDR_WIDTH = 32,
   parameter int unsigned C_AXIMM_DATA_WIDTH = 32,
   parameter int unsigned C_AXIMM_ID_WIDTH   = 1,
   parameter int unsigned C_AXIMM_USER_WIDTH = 1,
   parameter logic [1:0]  C_RESP             = 2'b11
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   // write address
   input  logic [C_AXIMM_ID_WIDTH-1:0]     S_AXIMM_AWID,
   input  logic [C_AXIMM_ADDR_WIDTH-1:0]   S_AXIMM_AWADDR,
   input  logic [7:0]                      S_AXIMM_AWLEN,
   input  logic [2:0]                      S_AXIMM_AWSIZE,
   input  logic [1:0]                      S_AXIMM_AWBURST,
   input  logic                            S_AXIMM_AWLOCK,
   input  logic [3:0]                      S_AXIMM_AWCACHE,
   input  logic [2:0]                      S_AXIMM_AWPROT,
   input  logic [3:0]                      S_AXIMM_AWREGION,
   input  logic [3:0]                      S_AXIMM_AWQOS,
   input  logic [C_AXIMM_USER_WIDTH-1:0]   S_AXIMM_AWUSER,
   input  logic                            S_AXIMM_AWVALID,
   output logic                            S_AXIMM_AWREADY,
   // write data
   input  logic [C_AXIMM_DATA_WIDTH-1:0]   S_AXIMM_WDATA,
   input  logic [C_AXIMM_DATA_WIDTH/8-1:0] S_AXIMM_WSTRB,
   input  logic [C_AXIMM_USER_WIDTH-1:0]   S_AXIMM_WUSER,
   input  logic                            S_AXIMM_WLAST,
   input  logic                            S_AXIMM_WVALID,
   output logic                            S_AXIMM_WREADY,
   // write response
   output logic [C_AXIMM_ID_WIDTH-1:0]     S_AXIMM_BID,
   output logic [1:0]                      S_AXIMM_BRESP,
   output logic                            S_AXIMM_BVALID,
   input  logic                            S_AXIMM_BREADY,
   // read address
   input  logic [C_AXIMM_ID_WIDTH-1:0]     S_AXIMM_ARID,
   input  logic [C_AXIMM_ADDR_WIDTH-1:0]   S_AXIMM_ARADDR,
   input  logic [7:0]                      S_AXIMM_ARLEN,
   input  logic [2:0]                      S_AXIMM_ARSIZE,
   input  logic [1:0]                      S_AXIMM_ARBURST,
   input  logic                            S_AXIMM_ARLOCK,
   input  logic [3:0]                      S_AXIMM_ARCACHE,
   input  logic [2:0]                      S_AXIMM_ARPROT,
   input  logic [3:0]                      S_AXIMM_ARREGION,
   input  logic [3:0]                      S_AXIMM_ARQOS,
   input  logic [C_AXIMM_USER_WIDTH-1:0]   S_AXIMM_ARUSER,
   input  logic                            S_AXIMM_ARVALID,
   output logic                            S_AXIMM_ARREADY,
   // read data
   output logic [C_AXIMM_ID_WIDTH-1:0]     S_AXIMM_RID,
   output logic [C_AXIMM_DATA_WIDTH-1:0]   S_AXIMM_RDATA,
   output logic [1:0]                      S_AXIMM_RRESP,
   output logic                            S_AXIMM_RLAST,
   output logic                            S_AXIMM_RVALID,
   input  logic                            S_AXIMM_RREADY
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   w_state_t                    w_state, w_state_nxt;
   logic [C_AXIMM_ID_WIDTH-1:0] bid_nxt;
   r_state_t                    r_state, r_state_nxt;
   logic [7:0]                  r_cnt, r_cnt_nxt;
   logic [C_AXIMM_ID_WIDTH-1:0] rid_nxt;

   logic unused_inputs;
   assign unused_inputs = ^{S_AXIMM_AWADDR, S_AXIMM_AWLEN, S_AXIMM_AWSIZE, S_AXIMM_AWBURST,
                            S_AXIMM_AWLOCK, S_AXIMM_AWCACHE, S_AXIMM_AWPROT, S_AXIMM_AWREGION,
                            S_AXIMM_AWQOS, S_AXIMM_AWUSER, S_AXIMM_WDATA, S_AXIMM_WSTRB,
                            S_AXIMM_WUSER, S_AXIMM_ARADDR, S_AXIMM_ARSIZE, S_AXIMM_ARBURST,
                            S_AXIMM_ARLOCK, S_AXIMM_ARCACHE, S_AXIMM_ARPROT, S_AXIMM_ARREGION,
                            S_AXIMM_ARQOS, S_AXIMM_ARUSER};

   assign S_AXIMM_RDATA = '0;

   always_comb begin
      w_state_nxt = w_state;
      bid_nxt     = S_AXIMM_BID;
      case (w_state)
         W_IDLE:
            if (S_AXIMM_AWVALID && S_AXIMM_AWREADY) begin
               w_state_nxt = W_DATA;
               bid_nxt     = S_AXIMM_AWID;
            end
         W_DATA:
            if (S_AXIMM_WVALID && S_AXIMM_WREADY && S_AXIMM_WLAST) w_state_nxt = W_RESP;
         W_RESP:
            if (S_AXIMM_BVALID && S_AXIMM_BREADY) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Outputs are registered decodes of the next state, so they are all low
   // during reset and READY appears only on the first cycle after release.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state         <= W_IDLE;
         S_AXIMM_AWREADY <= 1'b0;
         S_AXIMM_WREADY  <= 1'b0;
         S_AXIMM_BVALID  <= 1'b0;
         S_AXIMM_BRESP   <= '0;
         S_AXIMM_BID     <= '0;
      end else begin
         w_state         <= w_state_nxt;
         S_AXIMM_AWREADY <= (w_state_nxt == W_IDLE);
         S_AXIMM_WREADY  <= (w_state_nxt == W_DATA);
         S_AXIMM_BVALID  <= (w_state_nxt == W_RESP);
         S_AXIMM_BRESP   <= (w_state_nxt == W_RESP) ? C_RESP : 2'b00;
         S_AXIMM_BID     <= bid_nxt;
      end
   end

   always_comb begin
      r_state_nxt = r_state;
      r_cnt_nxt   = r_cnt;
      rid_nxt     = S_AXIMM_RID;
      case (r_state)
         R_IDLE:
            if (S_AXIMM_ARVALID && S_AXIMM_ARREADY) begin
               r_state_nxt = R_DATA;
               r_cnt_nxt   = S_AXIMM_ARLEN;
               rid_nxt     = S_AXIMM_ARID;
            end
         R_DATA:
            if (S_AXIMM_RVALID && S_AXIMM_RREADY) begin
               if (r_cnt == 8'd0) r_state_nxt = R_IDLE;
               else               r_cnt_nxt   = r_cnt - 8'd1;
            end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state         <= R_IDLE;
         r_cnt           <= '0;
         S_AXIMM_ARREADY <= 1'b0;
         S_AXIMM_RVALID  <= 1'b0;
         S_AXIMM_RLAST   <= 1'b0;
         S_AXIMM_RRESP   <= '0;
         S_AXIMM_RID     <= '0;
      end else begin
         r_state         <= r_state_nxt;
         r_cnt           <= r_cnt_nxt;
         S_AXIMM_ARREADY <= (r_state_nxt == R_IDLE);
         S_AXIMM_RVALID  <= (r_state_nxt == R_DATA);
         S_AXIMM_RLAST   <= (r_state_nxt == R_DATA) && (r_cnt_nxt == 8'd0);
         S_AXIMM_RRESP   <= (r_state_nxt == R_DATA) ? C_RESP : 2'b00;
         S_AXIMM_RID     <= rid_nxt;
      end
   end

endmodule

// File: tb/tb_aximm_error_slave.sv
// Directed bench for aximm_error_slave: reset, write/read bursts, stalls,
// concurrent channels and mid-burst reset.
module tb_aximm_error_slave;

   logic        clk = 1'b0;
   logic        areset;
   logic [0:0]  awid, bid, arid, rid;
   logic        awvalid, awready, wlast, wvalid, wready;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready;
   logic [7:0]  arlen;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [31:0] rdata;

   logic [31:0] tie_addr = '0;
   logic [31:0] tie_data = '0;
   logic [3:0]  tie_strb = '0;
   logic [7:0]  tie_len  = '0;
   logic [2:0]  tie3     = '0;
   logic [1:0]  tie2     = '0;
   logic [3:0]  tie4     = '0;
   logic        tie1     = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   aximm_error_slave #(.C_AXIMM_ADDR_WIDTH(32), .C_AXIMM_DATA_WIDTH(32),
                       .C_AXIMM_ID_WIDTH(1), .C_RESP(2'b11)) dut (
      .ACLK(clk), .ARESET(areset),
      .S_AXIMM_AWID(awid), .S_AXIMM_AWADDR(tie_addr), .S_AXIMM_AWLEN(tie_len),
      .S_AXIMM_AWSIZE(tie3), .S_AXIMM_AWBURST(tie2), .S_AXIMM_AWLOCK(tie1),
      .S_AXIMM_AWCACHE(tie4), .S_AXIMM_AWPROT(tie3), .S_AXIMM_AWREGION(tie4),
      .S_AXIMM_AWQOS(tie4), .S_AXIMM_AWUSER(tie1), .S_AXIMM_AWVALID(awvalid),
      .S_AXIMM_AWREADY(awready),
      .S_AXIMM_WDATA(tie_data), .S_AXIMM_WSTRB(tie_strb), .S_AXIMM_WUSER(tie1),
      .S_AXIMM_WLAST(wlast), .S_AXIMM_WVALID(wvalid), .S_AXIMM_WREADY(wready),
      .S_AXIMM_BID(bid), .S_AXIMM_BRESP(bresp), .S_AXIMM_BVALID(bvalid),
      .S_AXIMM_BREADY(bready),
      .S_AXIMM_ARID(arid), .S_AXIMM_ARADDR(tie_addr), .S_AXIMM_ARLEN(arlen),
      .S_AXIMM_ARSIZE(tie3), .S_AXIMM_ARBURST(tie2), .S_AXIMM_ARLOCK(tie1),
      .S_AXIMM_ARCACHE(tie4), .S_AXIMM_ARPROT(tie3), .S_AXIMM_ARREGION(tie4),
      .S_AXIMM_ARQOS(tie4), .S_AXIMM_ARUSER(tie1), .S_AXIMM_ARVALID(arvalid),
      .S_AXIMM_ARREADY(arready),
      .S_AXIMM_RID(rid), .S_AXIMM_RDATA(rdata), .S_AXIMM_RRESP(rresp),
      .S_AXIMM_RLAST(rlast), .S_AXIMM_RVALID(rvalid), .S_AXIMM_RREADY(rready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // AR handshake then drain the burst, checking every presented beat.
   task automatic run_read(input int len, input logic [0:0] id, input bit toggle);
      int beat;
      int cyc;
      check("ar_ready_pre", {31'd0, arready}, 32'd1);
      arvalid = 1'b1; arlen = 8'(len); arid = id;
      tick;
      arvalid = 1'b0;
      check("ar_ready_busy", {31'd0, arready}, 32'd0);
      beat = 0;
      cyc  = 0;
      while (beat <= len && cyc < 2000) begin
         check("r_valid", {31'd0, rvalid}, 32'd1);
         check("r_last",  {31'd0, rlast},  {31'd0, beat == len});
         check("r_id",    {31'd0, rid},    {31'd0, id});
         check("r_data",  rdata,           32'd0);
         check("r_resp",  {30'd0, rresp},  32'd3);
         rready = toggle ? (cyc % 2 == 0) : 1'b1;
         tick;
         if (rready) beat++;
         cyc++;
      end
      rready = 1'b0;
      check("r_beats", beat, len + 1);
      check("r_valid_end", {31'd0, rvalid}, 32'd0);
      check("ar_ready_end", {31'd0, arready}, 32'd1);
   endtask

   initial begin
      areset = 1'b1; awid = '0; awvalid = 1'b1; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; arlen = '0; arvalid = 1'b1; rready = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick;
         check("rst_outputs", {20'd0, awready, wready, bvalid, bid, bresp,
                               arready, rvalid, rlast, rid, rresp}, 32'd0);
         check("rst_rdata", rdata, 32'd0);
      end
      areset = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
      tick;
      check("rel_awready", {31'd0, awready}, 32'd1);
      check("rel_arready", {31'd0, arready}, 32'd1);
      check("rel_wready",  {31'd0, wready},  32'd0);

      // 4-beat write; W offered before AW must stall
      wvalid = 1'b1;
      tick;
      check("w_stall", {31'd0, wready}, 32'd0);
      wvalid = 1'b0; awvalid = 1'b1; awid = 1'b1;
      tick;
      awvalid = 1'b0;
      check("aw_drop", {31'd0, awready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("w_ready", {31'd0, wready}, 32'd1);
         check("w_nob",   {31'd0, bvalid}, 32'd0);
         wvalid = 1'b1; wlast = (i == 3);
         tick;
      end
      wvalid = 1'b0; wlast = 1'b0;
      check("w_done_ready", {31'd0, wready}, 32'd0);
      check("b_valid", {31'd0, bvalid}, 32'd1);
      check("b_id",    {31'd0, bid},    32'd1);
      check("b_resp",  {30'd0, bresp},  32'd3);
      bready = 1'b1;
      tick;
      check("b_gone", {31'd0, bvalid}, 32'd0);
      check("aw_back", {31'd0, awready}, 32'd1);
      tick;
      check("b_once", {31'd0, bvalid}, 32'd0);
      bready = 1'b0;

      run_read(3, 1'b1, 1'b1);
      run_read(255, 1'b0, 1'b0);

      // concurrent AW and AR, B back-pressured
      awvalid = 1'b1; awid = 1'b0; arvalid = 1'b1; arid = 1'b1; arlen = 8'd0;
      tick;
      awvalid = 1'b0; arvalid = 1'b0;
      check("cc_awready", {31'd0, awready}, 32'd0);
      check("cc_arready", {31'd0, arready}, 32'd0);
      check("cc_wready",  {31'd0, wready},  32'd1);
      check("cc_rvalid",  {31'd0, rvalid},  32'd1);
      check("cc_rlast",   {31'd0, rlast},   32'd1);
      check("cc_rid",     {31'd0, rid},     32'd1);
      wvalid = 1'b1; wlast = 1'b1; rready = 1'b1;
      tick;
      wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
      check("cc_r_done", {31'd0, rvalid}, 32'd0);
      check("cc_ar_back", {31'd0, arready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("cc_b_hold", {29'd0, bvalid, bid, 1'b0}, 32'd4);
         check("cc_b_resp", {30'd0, bresp}, 32'd3);
         tick;
      end
      check("cc_b_valid", {31'd0, bvalid}, 32'd1);
      bready = 1'b1;
      tick;
      bready = 1'b0;
      check("cc_b_done", {31'd0, bvalid}, 32'd0);
      check("cc_aw_back", {31'd0, awready}, 32'd1);

      // reset while beat 2 of an 8-beat read is presented
      arvalid = 1'b1; arlen = 8'd7; arid = 1'b1;
      tick;
      arvalid = 1'b0; rready = 1'b1;
      tick;
      rready = 1'b0;
      check("mr_beat2", {30'd0, rvalid, rlast}, 32'd2);
      areset = 1'b1;
      tick;
      check("mr_rvalid", {31'd0, rvalid}, 32'd0);
      check("mr_arready", {31'd0, arready}, 32'd0);
      areset = 1'b0;
      tick;
      check("mr_rel_rvalid", {31'd0, rvalid}, 32'd0);
      run_read(0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
